// File: rtl/slc3_datapath_param.sv
// SLC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, ALU, address adder,
// shared bus with contention detection, NZP condition codes and registered BEN.
module slc3_datapath_param #(
  parameter int unsigned           DATA_W   = 16,
  parameter logic [DATA_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LD_REG,
  input  logic              LD_BEN,
  input  logic              LD_CC,
  input  logic              LD_IR,
  input  logic              LD_PC,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              GateALU,
  input  logic              GatePC,
  input  logic              GateMARMUX,
  input  logic              GateMDR,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  input  logic              ADDR1MUX,
  input  logic              MIO_EN,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic [1:0]        PCMUX,
  input  logic [DATA_W-1:0] MDR_In,
  output logic              BEN,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] bus,
  output logic [2:0]        cc,
  output logic              bus_conflict
);

  logic [DATA_W-1:0] r_pc, r_ir, r_mar, r_mdr;
  logic [DATA_W-1:0] r_regs [8];
  logic [2:0]        r_cc;
  logic              r_ben;

  logic [2:0]        w_dr, w_sr1, w_sr2;
  logic [DATA_W-1:0] w_sr1_val, w_sr2_val;
  logic [DATA_W-1:0] w_sext5, w_sext6, w_sext9, w_sext11;
  logic [DATA_W-1:0] w_alu_b, w_alu;
  logic [DATA_W-1:0] w_addr1, w_addr2, w_sum;
  logic [DATA_W-1:0] w_pc_inc, w_pc_next;
  logic [DATA_W-1:0] w_bus;
  logic              w_conflict;
  logic [2:0]        w_cc_next;

  assign w_dr  = DRMUX  ? 3'd7      : r_ir[11:9];
  assign w_sr1 = SR1MUX ? r_ir[8:6] : r_ir[11:9];
  assign w_sr2 = r_ir[2:0];

  assign w_sr1_val = r_regs[w_sr1];
  assign w_sr2_val = r_regs[w_sr2];

  assign w_sext5  = {{(DATA_W-5){r_ir[4]}},   r_ir[4:0]};
  assign w_sext6  = {{(DATA_W-6){r_ir[5]}},   r_ir[5:0]};
  assign w_sext9  = {{(DATA_W-9){r_ir[8]}},   r_ir[8:0]};
  assign w_sext11 = {{(DATA_W-11){r_ir[10]}}, r_ir[10:0]};

  assign w_alu_b = r_ir[5] ? w_sext5 : w_sr2_val;

  always_comb begin
    w_alu = w_sr1_val;
    case (ALUK)
      2'b00:   w_alu = w_sr1_val + w_alu_b;
      2'b01:   w_alu = w_sr1_val & w_alu_b;
      2'b10:   w_alu = ~w_sr1_val;
      default: w_alu = w_sr1_val;
    endcase
  end

  assign w_addr1 = ADDR1MUX ? w_sr1_val : r_pc;

  always_comb begin
    w_addr2 = '0;
    case (ADDR2MUX)
      2'b00:   w_addr2 = '0;
      2'b01:   w_addr2 = w_sext6;
      2'b10:   w_addr2 = w_sext9;
      default: w_addr2 = w_sext11;
    endcase
  end

  assign w_sum = w_addr1 + w_addr2;

  // Any pair of gates driving together is contention; bus is forced to 0.
  assign w_conflict = (GateALU & GatePC) | (GateALU & GateMARMUX) |
                      (GateALU & GateMDR) | (GatePC & GateMARMUX) |
                      (GatePC & GateMDR) | (GateMARMUX & GateMDR);

  always_comb begin
    w_bus = '0;
    if (!w_conflict) begin
      if (GateMARMUX)   w_bus = w_sum;
      else if (GatePC)  w_bus = r_pc;
      else if (GateALU) w_bus = w_alu;
      else if (GateMDR) w_bus = r_mdr;
    end
  end

  assign w_pc_inc = r_pc + {{(DATA_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_pc_next = r_pc;
    case (PCMUX)
      2'b00:   w_pc_next = w_pc_inc;
      2'b01:   w_pc_next = w_bus;
      2'b10:   w_pc_next = w_sum;
      default: w_pc_next = r_pc;
    endcase
  end

  always_comb begin
    if (w_bus[DATA_W-1])  w_cc_next = 3'b100;
    else if (w_bus == '0) w_cc_next = 3'b010;
    else                  w_cc_next = 3'b001;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_PC;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_cc  <= 3'b010;
      r_ben <= 1'b0;
    end else begin
      if (LD_PC)  r_pc  <= w_pc_next;
      if (LD_IR)  r_ir  <= w_bus;
      if (LD_MAR) r_mar <= w_bus;
      if (LD_MDR) r_mdr <= MIO_EN ? MDR_In : w_bus;
      if (LD_CC)  r_cc  <= w_cc_next;
      // BEN samples the pre-edge IR and cc.
      if (LD_BEN) r_ben <= (r_ir[11] & r_cc[2]) | (r_ir[10] & r_cc[1]) |
                           (r_ir[9] & r_cc[0]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (LD_REG) begin
      r_regs[w_dr] <= w_bus;
    end
  end

  assign PC           = r_pc;
  assign IR           = r_ir;
  assign MAR          = r_mar;
  assign MDR          = r_mdr;
  assign cc           = r_cc;
  assign BEN          = r_ben;
  assign bus          = w_bus;
  assign bus_conflict = w_conflict;

endmodule

// File: tb/tb_slc3_datapath_param.sv
// Scoreboard bench for slc3_datapath_param: 16-bit main instance plus a
// 32-bit instance sharing the controls for the wide address-adder check.
module tb_slc3_datapath_param;

  localparam int unsigned SEL_PC = 0, SEL_IR = 1, SEL_MAR = 2, SEL_MDR = 3,
                          SEL_BUS = 4, SEL_CC = 5, SEL_BEN = 6, SEL_CONF = 7,
                          SEL_BUS32 = 8;

  logic clk = 1'b0;
  logic reset;
  logic LD_REG, LD_BEN, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR;
  logic GateALU, GatePC, GateMARMUX, GateMDR;
  logic DRMUX, SR1MUX, ADDR1MUX, MIO_EN;
  logic [1:0] ADDR2MUX, ALUK, PCMUX;
  logic [15:0] MDR_In;
  logic [31:0] MDR_In32;

  logic        BEN, bus_conflict;
  logic [15:0] IR, PC, MAR, MDR, bus;
  logic [2:0]  cc;

  logic        BEN32, bus_conflict32;
  logic [31:0] IR32, PC32, MAR32, MDR32, bus32;
  logic [2:0]  cc32;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  slc3_datapath_param #(.DATA_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset(reset),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_IR(LD_IR),
    .LD_PC(LD_PC), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .PCMUX(PCMUX), .MDR_In(MDR_In),
    .BEN(BEN), .IR(IR), .PC(PC), .MAR(MAR), .MDR(MDR), .bus(bus), .cc(cc),
    .bus_conflict(bus_conflict)
  );

  slc3_datapath_param #(.DATA_W(32), .RESET_PC(32'h0000_0000)) u_dut32 (
    .clk(clk), .reset(reset),
    .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_IR(LD_IR),
    .LD_PC(LD_PC), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .PCMUX(PCMUX), .MDR_In(MDR_In32),
    .BEN(BEN32), .IR(IR32), .PC(PC32), .MAR(MAR32), .MDR(MDR32), .bus(bus32),
    .cc(cc32), .bus_conflict(bus_conflict32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int unsigned sel);
    case (sel)
      SEL_PC:    return {16'h0, PC};
      SEL_IR:    return {16'h0, IR};
      SEL_MAR:   return {16'h0, MAR};
      SEL_MDR:   return {16'h0, MDR};
      SEL_BUS:   return {16'h0, bus};
      SEL_CC:    return {29'h0, cc};
      SEL_BEN:   return {31'h0, BEN};
      SEL_CONF:  return {31'h0, bus_conflict};
      default:   return bus32;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int unsigned sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    {LD_REG, LD_BEN, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR} = '0;
    {GateALU, GatePC, GateMARMUX, GateMDR} = '0;
    {DRMUX, SR1MUX, ADDR1MUX, MIO_EN} = '0;
    ADDR2MUX = 2'b00; ALUK = 2'b00; PCMUX = 2'b00;
  endtask

  // Clock edge, then compare everything queued for this edge; leave controls idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic load_mdr(input logic [15:0] v);
    idle();
    MIO_EN = 1'b1; LD_MDR = 1'b1; MDR_In = v; MDR_In32 = {16'h0, v};
    step();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    MDR_In = '0; MDR_In32 = '0;
    reset = 1'b0;
    #12;
    reset = 1'b1;
    @(negedge clk);
    expect_val("rst_pc", SEL_PC, 32'h0);
    expect_val("rst_ir", SEL_IR, 32'h0);
    expect_val("rst_mar", SEL_MAR, 32'h0);
    expect_val("rst_mdr", SEL_MDR, 32'h0);
    expect_val("rst_cc", SEL_CC, 32'h2);
    expect_val("rst_ben", SEL_BEN, 32'h0);
    expect_val("idle_bus", SEL_BUS, 32'h0);
    expect_val("idle_conf", SEL_CONF, 32'h0);
    settle();

    // Populate state, then reset mid-sequence with loads active.
    load_mdr(16'h1234);
    GateMDR = 1; LD_PC = 1; PCMUX = 2'b01; LD_MAR = 1; LD_IR = 1; LD_CC = 1;
    expect_val("pre_pc", SEL_PC, 32'h1234);
    expect_val("pre_ir", SEL_IR, 32'h1234);
    expect_val("pre_cc", SEL_CC, 32'h1);
    step();
    GatePC = 1; LD_PC = 1; PCMUX = 2'b00;
    reset = 1'b0;
    #2;
    expect_val("arst_pc", SEL_PC, 32'h0);
    expect_val("arst_ir", SEL_IR, 32'h0);
    expect_val("arst_mar", SEL_MAR, 32'h0);
    expect_val("arst_mdr", SEL_MDR, 32'h0);
    expect_val("arst_cc", SEL_CC, 32'h2);
    expect_val("arst_ben", SEL_BEN, 32'h0);
    drain();
    @(posedge clk); #1;
    expect_val("arst_edge_pc", SEL_PC, 32'h0);
    drain();
    idle();
    reset = 1'b1;
    expect_val("rel_pc", SEL_PC, 32'h0);
    step();

    // Fetch from 0x3000.
    load_mdr(16'h3000);
    GateMDR = 1; LD_PC = 1; PCMUX = 2'b01;
    expect_val("pc_bus", SEL_PC, 32'h3000);
    step();
    GatePC = 1; LD_MAR = 1; LD_PC = 1; PCMUX = 2'b00;
    expect_val("fetch_mar", SEL_MAR, 32'h3000);
    expect_val("fetch_pc", SEL_PC, 32'h3001);
    step();
    MDR_In = 16'h1261; MDR_In32 = 32'h1261;
    MIO_EN = 1; LD_MDR = 1;
    expect_val("fetch_mdr", SEL_MDR, 32'h1261);
    step();
    GateMDR = 1; LD_IR = 1;
    expect_val("fetch_ir", SEL_IR, 32'h1261);
    step();

    // ADD R1,R1,#1 with R1=5, then with R1=0xFFFF.
    load_mdr(16'h0005);
    GateMDR = 1; LD_REG = 1;
    step();
    SR1MUX = 1; ALUK = 2'b11; GateALU = 1;
    expect_val("r1_five", SEL_BUS, 32'h5);
    settle();
    idle();
    SR1MUX = 1; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1;
    expect_val("add_bus", SEL_BUS, 32'h6);
    settle();
    expect_val("add_cc_pos", SEL_CC, 32'h1);
    step();
    SR1MUX = 1; ALUK = 2'b11; GateALU = 1;
    expect_val("r1_six", SEL_BUS, 32'h6);
    settle();
    load_mdr(16'hFFFF);
    GateMDR = 1; LD_REG = 1;
    step();
    SR1MUX = 1; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1;
    expect_val("add_wrap_bus", SEL_BUS, 32'h0);
    settle();
    expect_val("add_cc_zero", SEL_CC, 32'h2);
    step();
    SR1MUX = 1; ALUK = 2'b11; GateALU = 1;
    expect_val("r1_zero", SEL_BUS, 32'h0);
    settle();

    // BRz and BEN timing.
    load_mdr(16'h0402);
    GateMDR = 1; LD_IR = 1;
    expect_val("br_ir", SEL_IR, 32'h0402);
    step();
    LD_BEN = 1;
    expect_val("ben_z", SEL_BEN, 32'h1);
    step();
    GatePC = 1; LD_CC = 1;
    expect_val("cc_pc_pos", SEL_CC, 32'h1);
    expect_val("ben_hold", SEL_BEN, 32'h1);
    step();
    LD_BEN = 1;
    expect_val("ben_p", SEL_BEN, 32'h0);
    step();
    LD_CC = 1; LD_BEN = 1;
    expect_val("ben_old_cc", SEL_BEN, 32'h0);
    expect_val("cc_bus0", SEL_CC, 32'h2);
    step();
    LD_BEN = 1;
    expect_val("ben_new_cc", SEL_BEN, 32'h1);
    step();

    // NOT of R2 (=0) gives all ones and a negative cc.
    ALUK = 2'b10; GateALU = 1; LD_CC = 1;
    expect_val("not_bus", SEL_BUS, 32'hFFFF);
    settle();
    expect_val("cc_neg", SEL_CC, 32'h4);
    step();

    // Address adder and PC mux.
    ADDR1MUX = 0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1; GateMARMUX = 1;
    expect_val("sum_sext9", SEL_BUS, 32'h3003);
    settle();
    expect_val("pc_sum", SEL_PC, 32'h3003);
    step();
    PCMUX = 2'b11; LD_PC = 1;
    expect_val("pc_hold", SEL_PC, 32'h3003);
    step();
    GateMARMUX = 1; ADDR1MUX = 1; SR1MUX = 1; ADDR2MUX = 2'b01;
    expect_val("sum_sext6", SEL_BUS, 32'h0002);
    settle();
    ADDR1MUX = 0; ADDR2MUX = 2'b11;
    expect_val("sum_sext11", SEL_BUS, 32'h2C05);
    settle();
    ADDR2MUX = 2'b00;
    expect_val("sum_zero_off", SEL_BUS, 32'h3003);
    settle();
    idle();

    // PC increment wraps.
    load_mdr(16'hFFFF);
    GateMDR = 1; LD_PC = 1; PCMUX = 2'b01;
    expect_val("pc_ffff", SEL_PC, 32'hFFFF);
    step();
    LD_PC = 1; PCMUX = 2'b00;
    expect_val("pc_wrap", SEL_PC, 32'h0);
    step();

    // Bus contention.
    load_mdr(16'h3000);
    GateMDR = 1; LD_MAR = 1;
    expect_val("mar_3000", SEL_MAR, 32'h3000);
    step();
    GatePC = 1; GateALU = 1; LD_MAR = 1;
    expect_val("conf_bus", SEL_BUS, 32'h0);
    expect_val("conf_flag", SEL_CONF, 32'h1);
    settle();
    expect_val("conf_mar", SEL_MAR, 32'h0);
    step();
    expect_val("conf_clear", SEL_CONF, 32'h0);
    settle();

    // Wide sign extension on the 32-bit instance with ADDR1 = PC = 0.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    load_mdr(16'h01FF);
    GateMDR = 1; LD_IR = 1;
    step();
    ADDR1MUX = 0; ADDR2MUX = 2'b10; GateMARMUX = 1;
    expect_val("sum16_neg1", SEL_BUS, 32'h0000_FFFF);
    expect_val("sum32_neg1", SEL_BUS32, 32'hFFFF_FFFF);
    settle();
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/slc3_datapath_param.md
Name: slc3_datapath_param

Overview:
- Parametrised next-generation SLC-3 datapath: PC, IR, MAR, MDR, register file, ALU, address adder and shared bus, with condition codes and branch-enable generation.
- Sits between the control FSM, which drives all load/gate/mux selects, and the memory/IO interface, which supplies MDR_In.
- Adds over the previous generation:
  - configurable data width and reset PC
  - NZP condition-code register
  - registered BEN
  - a HOLD mode on the PC mux
  - bus-contention detection

Parameters:
DATA_W, 16, datapath/register width; must be >= 16; IR fields always sit in IR[15:0].
RESET_PC, 0, PC value loaded on reset (DATA_W bits).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
LD_REG, LD_BEN, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR  in  1 each  register load enables
GateALU, GatePC, GateMARMUX, GateMDR  in  1 each  bus source enables
DRMUX, SR1MUX, ADDR1MUX, MIO_EN  in  1 each  mux selects
ADDR2MUX, ALUK, PCMUX  in  2 each  mux selects
MDR_In  in  DATA_W  memory read data
BEN  out  1  registered branch enable
IR, PC, MAR, MDR  out  DATA_W each  register contents
bus  out  DATA_W  current bus value (debug)
cc  out  3  {N,Z,P}
bus_conflict  out  1  more than one gate asserted this cycle (combinational)

Behaviour:
- Reset (reset=0, async, dominates any load):
  - PC=RESET_PC; IR=MAR=MDR=0
  - all general registers R0..R7 = 0
  - cc=3'b010; BEN=0
- All register updates occur on the rising clk edge. Register-file reads are combinational, so a same-cycle read returns the pre-write value.
- sextK(x) sign-extends IR[K-1:0] to DATA_W.
- Bus sources (zero or one gate asserted):
  - GateMARMUX: adder sum
  - GatePC: PC
  - GateALU: ALU result
  - GateMDR: MDR
  - no gate asserted: bus=0
- Bus contention: two or more gates asserted → bus=0 and bus_conflict=1. Any asserted loads still capture 0. There is no sticky state.
- Register selects:
  - DR = DRMUX ? 3'd7 : IR[11:9]
  - SR1 = SR1MUX ? IR[8:6] : IR[11:9]
  - SR2 = IR[2:0]
- ALU: operand B = IR[5] ? sext5 : R[SR2]. ALUK selects:
  - 00: A+B, mod 2^DATA_W
  - 01: A&B
  - 10: ~A
  - 11: A (pass)
- Address adder:
  - ADDR1 = ADDR1MUX ? R[SR1] : PC
  - ADDR2MUX selects: 00→0, 01→sext6, 10→sext9, 11→sext11
  - sum = ADDR1+ADDR2, mod 2^DATA_W
- PC update (only when LD_PC=1). PCMUX selects:
  - 00: PC+1 (wraps all-ones→0)
  - 01: bus
  - 10: adder sum
  - 11: hold (PC unchanged even with LD_PC=1)
- Register loads:
  - LD_IR: IR←bus
  - LD_MAR: MAR←bus
  - LD_MDR: MDR ← MIO_EN ? MDR_In : bus
  - LD_REG: R[DR]←bus
- Condition codes, on LD_CC, bus treated as signed DATA_W:
  - cc = 100 if negative, 010 if zero, 001 if positive
  - exactly one bit is set at all times
- BEN, on LD_BEN: BEN ← (IR[11]&N)|(IR[10]&Z)|(IR[9]&P).
  - Uses the cc and IR values before the edge, so a simultaneous LD_CC or LD_IR is not seen.
  - BEN holds otherwise.
- All latencies are one clock, from control assertion to register output update.

Test Plan:
1. Drive reset=0 mid-sequence with LD_PC=1 and GatePC=1 → PC=RESET_PC (0x0000), IR=MAR=MDR=0, cc=010, BEN=0 immediately. Release reset → state holds until the next load.
2. Fetch with PC=0x3000: GatePC=1, LD_MAR=1, LD_PC=1, PCMUX=00 → MAR=0x3000, PC=0x3001. Next cycle: MIO_EN=1, MDR_In=0x1261, LD_MDR → MDR=0x1261. Then GateMDR, LD_IR → IR=0x1261.
3. R1=5, IR=0x1261 (ADD R1,R1,#1). Set SR1MUX=1, DRMUX=0, ALUK=00, GateALU, LD_REG, LD_CC → R1=6, cc=001. Repeat with R1=0xFFFF → R1=0x0000, cc=010.
4. IR=0x0402 (BRz), cc=010, LD_BEN=1 → BEN=1. Set cc=001, LD_BEN → BEN=0. Assert LD_CC (bus=0) and LD_BEN in the same cycle with cc=001 → BEN=0, cc=010.
5. PC=0x3001, IR=0x0402, ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC → PC=0x3003. PCMUX=11 with LD_PC=1 → PC stays 0x3003.
6. GatePC=1 and GateALU=1 together with LD_MAR=1 → bus=0, bus_conflict=1, MAR=0. Separately, a DATA_W=32 instance with IR[8:0]=0x1FF, ADDR2MUX=10, ADDR1=0 → sum=0xFFFFFFFF.
